// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one external fixed-latency signed multiplier among NREQ requesters.
// Optional MULT_ARBITER_PERF_EN adds transfer and credit-stall counters.
module mult_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int LAT   = 3,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    mul_valid_in,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic                    mul_valid_out,
  input  logic [2*WIDTH-1:0]      mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_p,
  output logic                    busy
`ifdef MULT_ARBITER_PERF_EN
  ,
  output logic [31:0]             perf_issue_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam int DEPTH = LAT + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int GW    = $clog2(LAT + 1);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     cand;
  logic               win_found;
  logic               credit_ok;
  logic               issue;
  logic [WIDTH-1:0]   win_a, win_b;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;

  logic               tag_v  [LAT];
  logic [IDW-1:0]     tag_id [LAT];
  logic               tag_out_v;
  logic [GW-1:0]      ign_cnt;
  logic               ign;
  logic               push, pop;
  logic               err_lat;

  logic [IDW-1:0]     fifo_id [DEPTH];
  logic [2*WIDTH-1:0] fifo_p  [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      fifo_count, inflight_count;
  logic [CW:0]        occupancy;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  // A pop in the same cycle frees its slot, which lets a steady stream issue every cycle.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_count} - {{CW{1'b0}}, pop};
  assign credit_ok = occupancy < (CW+1)'(DEPTH);
  assign issue     = rst_n && win_found && credit_ok;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[winner] = 1'b1;
  end

  assign win_a        = req_a[int'(winner)*WIDTH +: WIDTH];
  assign win_b        = req_b[int'(winner)*WIDTH +: WIDTH];
  assign mul_valid_in = issue;
  assign mul_a        = issue ? win_a : mul_a_q;
  assign mul_b        = issue ? win_b : mul_b_q;

  assign tag_out_v = tag_v[LAT-1];
  assign ign       = (ign_cnt != '0);
  assign push      = !ign && tag_out_v && mul_valid_out;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = fifo_id[rd_ptr];
  assign rsp_p     = fifo_p[rd_ptr];
  assign busy      = (inflight_count != '0) || (fifo_count != '0);

  // NOTE: all state updates use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      inflight_count <= '0;
      err_lat        <= 1'b0;
      ign_cnt        <= GW'(LAT);
      for (int k = 0; k < LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      if (issue) begin
        rr_ptr  <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
        mul_a_q <= win_a;
        mul_b_q <= win_b;
      end
      tag_v[0]  <= issue;
      tag_id[0] <= winner;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      // Results still draining from before a reset land inside this window and are ignored.
      if (ign) ign_cnt <= ign_cnt - 1'b1;
      if (!ign && (tag_out_v != mul_valid_out)) err_lat <= 1'b1;
      case ({issue, tag_out_v})
        2'b10:   inflight_count <= inflight_count + 1'b1;
        2'b01:   inflight_count <= inflight_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the result store is only LAT+1 entries, so it is reset and rsp_id/rsp_p read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        fifo_id[k] <= '0;
        fifo_p[k]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_id[wr_ptr] <= tag_id[LAT-1];
        fifo_p[wr_ptr]  <= mul_p;
        wr_ptr          <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULT_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((|req_valid) && !credit_ok) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
